// File: rtl/osd_trace_pkg.sv
// Shared types and helpers for the OSD trace arbiter: legal NUM_SRC range,
// source-index width function and the output-register FSM encoding.
package osd_trace_pkg;

  localparam int unsigned NumSrcMin = 2;
  localparam int unsigned NumSrcMax = 16;

  typedef enum logic {StEmpty, StFull} arb_state_e;

  function automatic int unsigned src_idx_w(input int unsigned num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage

// File: rtl/osd_trace_rr_grant.sv
// Pointer-based round-robin selection: first requester strictly after
// last_grant, modulo NUM_SRC. Purely combinational.
module osd_trace_rr_grant #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last_grant,
  output logic [NUM_SRC-1:0] grant_onehot,
  output logic [SRC_W-1:0]   grant_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    idx          = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(last_grant) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = SRC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/osd_trace_arbiter.sv
// Round-robin trace-beat arbiter with a one-entry output register.
// Optional drop counter enabled by defining OSD_TRACE_ARBITER_STATS_EN.
module osd_trace_arbiter
  import osd_trace_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned NUM_SRC = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SRC-1:0][WIDTH-1:0]    in_data,
  input  logic [NUM_SRC-1:0]               in_overflow,
  input  logic [NUM_SRC-1:0]               in_valid,
  output logic [NUM_SRC-1:0]               in_ready,
  input  logic [NUM_SRC-1:0]               src_enable,
  output logic [WIDTH-1:0]                 out_data,
  output logic                             out_overflow,
  output logic [src_idx_w(NUM_SRC)-1:0]    out_src,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [15:0]                      drop_count
);

  localparam int unsigned SrcW = src_idx_w(NUM_SRC);

  if (NUM_SRC < NumSrcMin || NUM_SRC > NumSrcMax) begin : g_num_src_check
    $error("osd_trace_arbiter: NUM_SRC out of range");
  end

  arb_state_e         state_q, state_d;
  logic               can_grant, grant;
  logic [NUM_SRC-1:0] req, grant_onehot, reach;
  logic [SrcW-1:0]    grant_idx, last_grant_q;
  logic               seen, blocked;
  int unsigned        idx;

  assign req = in_valid & src_enable;

  osd_trace_rr_grant #(
    .NUM_SRC(NUM_SRC),
    .SRC_W  (SrcW)
  ) u_rr_grant (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_onehot(grant_onehot),
    .grant_idx   (grant_idx)
  );

  // reach[i]: no other requester sits between last_grant and i, so source i would win
  // if valid. Ready is built from this so it never depends on the source's own in_valid.
  always_comb begin
    reach   = '0;
    seen    = 1'b0;
    blocked = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      seen    = 1'b0;
      blocked = 1'b0;
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
        idx = (32'(last_grant_q) + k) % NUM_SRC;
        if (idx == i) begin
          seen = 1'b1;
        end else if (!seen && req[idx]) begin
          blocked = 1'b1;
        end
      end
      reach[i] = !blocked;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (grant) state_d = StFull;
      StFull:  if (out_ready && !grant) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    can_grant = rst && ((state_q == StEmpty) || out_ready);
    grant     = can_grant && (|grant_onehot);
    out_valid = (state_q == StFull);
    in_ready  = {NUM_SRC{rst}} & (~src_enable | ({NUM_SRC{can_grant}} & reach));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data     <= '0;
      out_overflow <= 1'b0;
      out_src      <= '0;
      last_grant_q <= SrcW'(NUM_SRC - 1);
    end else if (grant) begin
      out_data     <= in_data[grant_idx];
      out_overflow <= in_overflow[grant_idx];
      out_src      <= grant_idx;
      last_grant_q <= grant_idx;
    end
  end

`ifdef OSD_TRACE_ARBITER_STATS_EN
  logic [15:0]        drop_q, drop_d;
  logic [4:0]         drops;
  logic [16:0]        drop_sum;
  logic [NUM_SRC-1:0] drop_mask;

  always_comb begin
    drop_mask = in_valid & ~src_enable;
    drops     = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (drop_mask[i]) drops = drops + 5'd1;
    end
    drop_sum = {1'b0, drop_q} + {12'b0, drops};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_osd_trace_arbiter.sv
// Self-checking bench for osd_trace_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_osd_trace_arbiter;

  localparam int NSRC = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NSRC-1:0][63:0]     in_data = '0;
  logic [NSRC-1:0]           in_overflow = '0;
  logic [NSRC-1:0]           in_valid = '0;
  logic [NSRC-1:0]           in_ready;
  logic [NSRC-1:0]           src_enable = '1;
  logic [63:0]               out_data;
  logic                      out_overflow;
  logic [1:0]                out_src;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [15:0]               drop_count;

  osd_trace_arbiter #(
    .WIDTH  (64),
    .NUM_SRC(NSRC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_overflow (in_overflow),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src_enable  (src_enable),
    .out_data    (out_data),
    .out_overflow(out_overflow),
    .out_src     (out_src),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: one held beat, a round-robin pointer and a drop tally.
  bit          m_full;
  logic [63:0] m_data;
  bit          m_ovf;
  int          m_src;
  int          m_last;
  int          m_drops;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    for (int k = 1; k <= NSRC; k++) begin
      int s;
      s = (m_last + k) % NSRC;
      if (in_valid[s] && src_enable[s]) return s;
    end
    return -1;
  endfunction

  function automatic int exp_drops();
`ifdef OSD_TRACE_ARBITER_STATS_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_full  = 0;
    m_data  = '0;
    m_ovf   = 0;
    m_src   = 0;
    m_last  = NSRC - 1;
    m_drops = 0;
  endtask

  task automatic compare();
    int  w;
    bit  cg;
    chk("out_valid", out_valid, m_full);
    chk("out_data", out_data, m_data);
    chk("out_overflow", out_overflow, m_ovf);
    chk("out_src", out_src, m_src);
    chk("drop_count", drop_count, exp_drops());
    w  = winner();
    cg = rst && (!m_full || out_ready);
    for (int i = 0; i < NSRC; i++) begin
      if (!rst) chk("in_ready_rst", in_ready[i], 1'b0);
      else if (!src_enable[i]) chk("in_ready_dis", in_ready[i], 1'b1);
      else if (in_valid[i]) chk("in_ready_req", in_ready[i], (cg && w == i));
    end
  endtask

  // Called at posedge+1 with inputs set; checks, then advances one clock.
  task automatic step();
    bit          n_full;
    logic [63:0] n_data;
    bit          n_ovf;
    int          n_src, n_last, n_drops, w;
    #1;
    compare();
    n_full = m_full; n_data = m_data; n_ovf = m_ovf;
    n_src = m_src; n_last = m_last; n_drops = m_drops;
    if (rst) begin
      w = winner();
      if ((!m_full || out_ready) && w >= 0) begin
        n_full = 1; n_data = in_data[w]; n_ovf = in_overflow[w];
        n_src = w; n_last = w;
      end else if (out_ready) begin
        n_full = 0;
      end
      n_drops = m_drops + $countones(in_valid & ~src_enable);
      if (n_drops > 65535) n_drops = 65535;
    end
    @(posedge clk);
    #1;
    m_full = n_full; m_data = n_data; m_ovf = n_ovf;
    m_src = n_src; m_last = n_last; m_drops = n_drops;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    repeat (2) step();
    rst = 1'b1;
  endtask

  int seq[5];
  int exp_seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    model_reset();
    src_enable = '0;
    in_valid   = '1;
    @(posedge clk);
    #1;
    // Reset state, disabled sources included.
    chk("reset_in_ready", in_ready, 4'h0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_drop", drop_count, 16'h0);
    step();
    src_enable = '1;
    in_valid   = '0;

    // Rotation across four always-valid sources.
    do_reset();
    out_ready = 1'b1;
    in_valid  = '1;
    for (int i = 0; i < NSRC; i++) in_data[i] = 64'h100 + 64'(i);
    step();
    for (int j = 0; j < 5; j++) begin
      seq[j] = int'(out_src);
      chk("rot_valid", out_valid, 1'b1);
      step();
    end
    for (int j = 0; j < 5; j++) chk("rot_seq", 64'(seq[j]), 64'(exp_seq[j]));

    // Backpressure: sources 1 and 3 contend while output is stalled.
    do_reset();
    in_valid  = 4'b1010;
    out_ready = 1'b0;
    step();
    for (int j = 0; j < 5; j++) begin
      chk("stall_src", out_src, 2'd1);
      chk("stall_rdy1", in_ready[1], 1'b0);
      chk("stall_rdy3", in_ready[3], 1'b0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("release_src", out_src, 2'd3);

    // Disabled source 2 is drained and discarded.
    do_reset();
    in_valid   = 4'b0100;
    src_enable = 4'b1011;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("dis_rdy2", in_ready[2], 1'b1);
      step();
    end
    in_valid = '0;
    step();
    chk("dis_no_out", out_valid, 1'b0);
`ifdef OSD_TRACE_ARBITER_STATS_EN
    chk("dis_drop3", drop_count, 16'd3);
`else
    chk("dis_drop0", drop_count, 16'd0);
`endif
    src_enable = '1;

    // Overflow flag and payload travel with the beat.
    in_valid       = 4'b0100;
    in_data[2]     = 64'hDEAD_BEEF;
    in_overflow[2] = 1'b1;
    step();
    chk("ovf_valid", out_valid, 1'b1);
    chk("ovf_src", out_src, 2'd2);
    chk("ovf_data", out_data, 64'hDEAD_BEEF);
    chk("ovf_flag", out_overflow, 1'b1);
    in_overflow = '0;

    // Asynchronous reset while FULL.
    in_valid  = '1;
    out_ready = 1'b0;
    step();
    chk("pre_rst_full", out_valid, 1'b1);
    #2;
    do_reset();
    out_ready = 1'b1;
    in_valid  = '1;
    step();
    chk("post_rst_src0", out_src, 2'd0);
    chk("post_rst_valid", out_valid, 1'b1);

    // Randomized traffic with occasional enable changes.
    for (int c = 0; c < 800; c++) begin
      in_valid    = NSRC'($urandom);
      in_overflow = NSRC'($urandom);
      for (int i = 0; i < NSRC; i++) in_data[i] = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      if (c % 60 == 0) src_enable = NSRC'($urandom);
      step();
    end

    // Saturation: 17500 cycles x 4 disabled sources = 70000 drops.
    do_reset();
    src_enable = '0;
    in_valid   = '1;
    out_ready  = 1'b1;
    repeat (17500) step();
`ifdef OSD_TRACE_ARBITER_STATS_EN
    chk("sat_drop", drop_count, 16'hFFFF);
`else
    chk("sat_drop0", drop_count, 16'h0);
`endif
    chk("sat_no_out", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/osd_trace_arbiter.md
OSD_TRACE_ARBITER -- requirements
Module: osd_trace_arbiter

Interface
REQ-001 Parameter WIDTH, default 64: trace beat payload width in bits.
REQ-002 Parameter NUM_SRC, default 4: number of trace sources; legal range is 2..16.
REQ-003 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset; 0 = in reset.
REQ-005 Port in_data, input, NUM_SRC x WIDTH: per-source payload.
REQ-006 Port in_overflow, input, NUM_SRC: per-source overflow flag, travelling with its beat.
REQ-007 Port in_valid, input, NUM_SRC: per-source valid.
REQ-008 Port in_ready, output, NUM_SRC: per-source ready.
REQ-009 Port src_enable, input, NUM_SRC: enable mask; driven quasi-static by the register layer.
REQ-010 Port out_data, output, WIDTH: granted payload.
REQ-011 Port out_overflow, output, 1: overflow flag of the granted beat.
REQ-012 Port out_src, output, $clog2(NUM_SRC): index of the granted source.
REQ-013 Port out_valid, output, 1: output valid.
REQ-014 Port out_ready, input, 1: packetizer ready.
REQ-015 Port drop_count, output, 16: count of beats discarded from disabled sources.

Function
REQ-016 A source beat SHALL transfer in any cycle where in_valid[i] and in_ready[i] are both 1.
REQ-017 A beat SHALL transfer at the output in any cycle where out_valid and out_ready are both 1.
REQ-018 A one-entry output register SHALL hold the granted beat; the FSM states are EMPTY and FULL.
- EMPTY to FULL: a beat is granted.
- FULL to EMPTY: the output transfers and no new beat is granted.
- FULL to FULL: the output transfers and a new beat is granted in the same cycle.
REQ-019 A beat accepted in cycle N SHALL appear with out_valid=1 in cycle N+1; throughput is one beat per cycle.
REQ-020 A grant is possible only when the FSM is EMPTY, or when it is FULL and out_ready=1.
REQ-021 When a grant is possible, in_ready[i] SHALL be 1 only for the single granted enabled source.
REQ-022 When the FSM is FULL and out_ready=0, every enabled in_ready SHALL be 0, and out_data, out_overflow and out_src SHALL stay stable.
REQ-023 Grant SHALL be round-robin by beat: the winner is the first enabled, valid source strictly after last_grant, taken modulo NUM_SRC.
REQ-024 last_grant SHALL update only on a grant; the reset value of last_grant is NUM_SRC-1, so source 0 wins first.
REQ-025 A disabled source SHALL see in_ready=1 permanently; its beats are discarded and never reach the output.
REQ-026 If src_enable[i] falls while source i's beat sits in the output register, that beat SHALL still be delivered.
REQ-027 A source's in_ready SHALL never combinationally depend on its own in_valid.
REQ-028 With no enabled valid source, no grant SHALL occur and out_valid SHALL fall after the current beat drains.

Reset
REQ-029 While rst=0, the block SHALL hold: out_valid=0, out_data=0, out_overflow=0, out_src=0, FSM=EMPTY, last_grant=NUM_SRC-1, drop_count=0.
REQ-030 While rst=0, in_ready SHALL be 0 for all sources, including disabled ones.
REQ-031 Reset asserted mid-transfer SHALL discard the held beat with no partial output.
REQ-032 The first grant SHALL be possible in the first rising edge after rst rises.

Configuration
REQ-033 With OSD_TRACE_ARBITER_STATS_EN defined, drop_count SHALL increment by 1 per discarded beat and saturate at 16'hFFFF.
REQ-034 In the same cycle, concurrent drops from k sources SHALL add k, still saturating at 16'hFFFF.
REQ-035 With OSD_TRACE_ARBITER_STATS_EN undefined, drop_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Structure
REQ-036 dii_package SHALL not be touched.
REQ-037 The source-index width function and the NUM_SRC legal-range constants SHALL live in a shared package, osd_trace_pkg.
REQ-038 The pointer-based round-robin selection SHALL be one combinational sub-module, osd_trace_rr_grant, with ports req, last_grant, grant_onehot and grant_idx.

Verification
REQ-039 Reset, then all 4 sources valid and enabled, out_ready=1 -> out_src sequence is 0,1,2,3,0 on consecutive cycles, first out_valid one cycle after the first accept.
REQ-040 Sources 1 and 3 valid, out_ready held 0 for 5 cycles -> out_src=1 stable for 5 cycles with in_ready=0; after release, the next out_src is 3.
REQ-041 src_enable=4'b1011 and source 2 sends 3 beats -> in_ready[2]=1 every cycle, no out_src=2 appears, and drop_count=3 with STATS_EN defined (0 with it undefined).
REQ-042 rst driven to 0 asynchronously mid-cycle while FULL -> out_valid falls immediately; after release, source 0 wins first.
REQ-043 Source 2 sends a beat with in_overflow=1 and data 64'hDEAD_BEEF -> the same beat shows out_overflow=1, out_data=64'hDEAD_BEEF, out_src=2.
REQ-044 With STATS_EN defined and 70000 drops applied -> drop_count=16'hFFFF.
